// File: rtl/fixed_point_divider_if.sv
// Start/busy/done handshake bundle between divider control and the divider.
// Control (master) launches a divide with operands; divider (slave) returns quotient and status flags.
interface fixed_point_divider_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
  logic         ovf;
  logic         dz;

  modport master (
    output start, a, b,
    input  busy, done, out, ovf, dz
  );

  modport slave (
    input  start, a, b,
    output busy, done, out, ovf, dz
  );
endinterface

// File: rtl/fixed_point_divider.sv
// Signed Q-format restoring divider, one quotient bit per cycle; done after N+Q+1 edges (1 for b=0).
// Start is ignored while busy; results hold until the next done pulse.
module fixed_point_divider #(
  parameter int Q = 20,
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fixed_point_divider_if.slave  bus
);
  localparam int W  = N + Q;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [N:0]     r_rem;
  logic [W-1:0]   r_dq;
  logic [N-1:0]   r_bmag;
  logic           r_sign;
  logic           r_asign;
  logic           r_dz;
  logic [N-1:0]   r_out;
  logic           r_ovf;
  logic           r_dz_out;
  logic           r_done;

  logic           w_b_zero;
  logic [N-1:0]   w_amag;
  logic [N-1:0]   w_bmag;
  logic [N:0]     w_shift;
  logic [N:0]     w_diff;
  logic           w_ge;
  logic [N-1:0]   w_res_out;
  logic           w_res_ovf;

  assign w_b_zero = (bus.b == '0);
  assign w_amag   = bus.a[N-1] ? ('0 - bus.a) : bus.a;
  assign w_bmag   = bus.b[N-1] ? ('0 - bus.b) : bus.b;

  // r_dq holds the unconsumed dividend bits at the top and collects quotient bits at the bottom.
  assign w_shift  = {r_rem[N-1:0], r_dq[W-1]};
  assign w_diff   = w_shift - {1'b0, r_bmag};
  assign w_ge     = (w_shift >= {1'b0, r_bmag});

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = w_b_zero ? FIX : CALC;
      CALC:    if (r_cnt == CW'(1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_res_out = '0;
    w_res_ovf = 1'b0;
    if (r_dz) begin
      w_res_out = r_asign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else if (!r_sign) begin
      w_res_ovf = |r_dq[W-1:N-1];
      w_res_out = w_res_ovf ? {1'b0, {(N-1){1'b1}}} : r_dq[N-1:0];
    end else begin
      // Magnitude 2^(N-1) is still representable as the most negative value.
      w_res_ovf = (|r_dq[W-1:N]) || (r_dq[N-1] && (|r_dq[N-2:0]));
      w_res_out = w_res_ovf ? {1'b1, {(N-1){1'b0}}} : ('0 - r_dq[N-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dq     <= '0;
      r_bmag   <= '0;
      r_sign   <= 1'b0;
      r_asign  <= 1'b0;
      r_dz     <= 1'b0;
      r_out    <= '0;
      r_ovf    <= 1'b0;
      r_dz_out <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dq    <= {w_amag, {Q{1'b0}}};
            r_rem   <= '0;
            r_bmag  <= w_bmag;
            r_sign  <= bus.a[N-1] ^ bus.b[N-1];
            r_asign <= bus.a[N-1];
            r_dz    <= w_b_zero;
            r_cnt   <= CW'(W);
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_diff : w_shift;
          r_dq  <= {r_dq[W-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        FIX: begin
          r_out    <= w_res_out;
          r_ovf    <= w_res_ovf;
          r_dz_out <= r_dz;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;
  assign bus.out  = r_out;
  assign bus.ovf  = r_ovf;
  assign bus.dz   = r_dz_out;
endmodule

// File: tb/tb_fixed_point_divider.sv
// Scoreboard bench for fixed_point_divider: expected results queued at launch, compared at done.
module tb_fixed_point_divider;
  localparam int N = 32;
  localparam int Q = 20;
  localparam int LAT = N + Q + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fixed_point_divider_if #(.N(N)) dif ();
  fixed_point_divider #(.Q(Q), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(dif));

  typedef struct packed {
    logic [N-1:0] out;
    logic         ovf;
    logic         dz;
  } res_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] out;
    logic         ovf;
    logic         dz;
    logic [7:0]   lat;
  } vec_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  res_t obs;
  res_t exp_r;
  int   obs_cyc;
  logic obs_to;
  logic obs_gap;

  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    res_t r;
    logic [63:0] am, bm, m;
    logic s;
    r = '0;
    s = a[N-1] ^ b[N-1];
    am = {32'd0, a[N-1] ? (~a + 32'd1) : a};
    bm = {32'd0, b[N-1] ? (~b + 32'd1) : b};
    if (b == 32'd0) begin
      r.dz  = 1'b1;
      r.out = a[N-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      m = (am << Q) / bm;
      if (!s) begin
        if (m > 64'h7FFF_FFFF) begin r.out = 32'h7FFF_FFFF; r.ovf = 1'b1; end
        else r.out = m[31:0];
      end else begin
        if (m > 64'h8000_0000) begin r.out = 32'h8000_0000; r.ovf = 1'b1; end
        else r.out = ~m[31:0] + 32'd1;
      end
    end
    return r;
  endfunction

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input res_t e);
    @(negedge clk);
    dif.start = 1'b1;
    dif.a     = a;
    dif.b     = b;
    sb.push_back(e);
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  // Returns with obs_cyc = number of edges after the accepting edge until done was seen.
  task automatic wait_done(input int budget);
    obs_cyc = 0;
    obs_to  = 1'b1;
    obs_gap = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dif.busy !== 1'b1) obs_gap = 1'b1;
      @(negedge clk);
      obs_cyc++;
      if (dif.done === 1'b1) begin
        obs_to = 1'b0;
        break;
      end
    end
    obs = {dif.out, dif.ovf, dif.dz};
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dif.busy, dif.done, dif.out, dif.ovf, dif.dz} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: busy=%b done=%b out=%h ovf=%b dz=%b, expected all zero",
               dif.busy, dif.done, dif.out, dif.ovf, dif.dz);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [N-1:0] held;
    launch(32'h0030_0000, 32'h0020_0000, '{out: 32'h0018_0000, ovf: 1'b0, dz: 1'b0});
    wait_done(100);
    exp_r = sb.pop_front();
    n_checks++;
    if (obs_to || obs_cyc != LAT) begin
      n_errors++;
      $display("FAIL basic_latency: done after %0d edges (timeout=%b), expected %0d", obs_cyc, obs_to, LAT);
    end
    n_checks++;
    if (obs !== exp_r) begin
      n_errors++;
      $display("FAIL basic_result: out=%h ovf=%b dz=%b, expected out=%h ovf=%b dz=%b",
               obs.out, obs.ovf, obs.dz, exp_r.out, exp_r.ovf, exp_r.dz);
    end
    n_checks++;
    if (obs_gap || dif.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_busy: gap=%b busy_at_done=%b, expected gap=0 busy_at_done=0", obs_gap, dif.busy);
    end
    held = dif.out;
    @(negedge clk);
    n_checks++;
    if (dif.done !== 1'b0 || dif.out !== held) begin
      n_errors++;
      $display("FAIL done_pulse: done=%b out=%h, expected done=0 out=%h", dif.done, dif.out, held);
    end
  endtask

  task automatic test_signed;
    vec_t v[2];
    v[0] = '{a: 32'hFFF0_0000, b: 32'h0030_0000, out: 32'hFFFA_AAAB, ovf: 1'b0, dz: 1'b0, lat: 8'(LAT)};
    v[1] = '{a: 32'h0010_0000, b: 32'hFFD0_0000, out: 32'hFFFA_AAAB, ovf: 1'b0, dz: 1'b0, lat: 8'(LAT)};
    for (int i = 0; i < 2; i++) begin
      launch(v[i].a, v[i].b, '{out: v[i].out, ovf: v[i].ovf, dz: v[i].dz});
      wait_done(100);
      exp_r = sb.pop_front();
      n_checks++;
      if (obs_to || obs !== exp_r || obs_cyc != int'(v[i].lat)) begin
        n_errors++;
        $display("FAIL signed_%0d: out=%h ovf=%b dz=%b lat=%0d, expected out=%h ovf=%b dz=%b lat=%0d",
                 i, obs.out, obs.ovf, obs.dz, obs_cyc, exp_r.out, exp_r.ovf, exp_r.dz, v[i].lat);
      end
    end
  endtask

  task automatic test_div_zero;
    vec_t v[2];
    v[0] = '{a: 32'h0010_0000, b: 32'h0, out: 32'h7FFF_FFFF, ovf: 1'b0, dz: 1'b1, lat: 8'd1};
    v[1] = '{a: 32'hFFF0_0000, b: 32'h0, out: 32'h8000_0000, ovf: 1'b0, dz: 1'b1, lat: 8'd1};
    for (int i = 0; i < 2; i++) begin
      launch(v[i].a, v[i].b, '{out: v[i].out, ovf: v[i].ovf, dz: v[i].dz});
      wait_done(100);
      exp_r = sb.pop_front();
      n_checks++;
      if (obs_to || obs !== exp_r || obs_cyc != int'(v[i].lat) || dif.busy !== 1'b0) begin
        n_errors++;
        $display("FAIL div_zero_%0d: out=%h ovf=%b dz=%b lat=%0d busy=%b, expected out=%h ovf=%b dz=%b lat=%0d busy=0",
                 i, obs.out, obs.ovf, obs.dz, obs_cyc, dif.busy, exp_r.out, exp_r.ovf, exp_r.dz, v[i].lat);
      end
    end
  endtask

  task automatic test_overflow;
    vec_t v[3];
    v[0] = '{a: 32'h4000_0000, b: 32'h0000_0001, out: 32'h7FFF_FFFF, ovf: 1'b1, dz: 1'b0, lat: 8'(LAT)};
    v[1] = '{a: 32'h8000_0000, b: 32'h0010_0000, out: 32'h8000_0000, ovf: 1'b0, dz: 1'b0, lat: 8'(LAT)};
    v[2] = '{a: 32'h8000_0000, b: 32'hFFF0_0000, out: 32'h7FFF_FFFF, ovf: 1'b1, dz: 1'b0, lat: 8'(LAT)};
    for (int i = 0; i < 3; i++) begin
      launch(v[i].a, v[i].b, '{out: v[i].out, ovf: v[i].ovf, dz: v[i].dz});
      wait_done(100);
      exp_r = sb.pop_front();
      n_checks++;
      if (obs_to || obs !== exp_r || obs_cyc != int'(v[i].lat)) begin
        n_errors++;
        $display("FAIL overflow_%0d: out=%h ovf=%b dz=%b lat=%0d, expected out=%h ovf=%b dz=%b lat=%0d",
                 i, obs.out, obs.ovf, obs.dz, obs_cyc, exp_r.out, exp_r.ovf, exp_r.dz, v[i].lat);
      end
    end
  endtask

  task automatic test_ignore_start;
    launch(32'h0030_0000, 32'h0020_0000, model(32'h0030_0000, 32'h0020_0000));
    repeat (9) @(negedge clk);
    dif.start = 1'b1;
    dif.a     = 32'h0050_0000;
    dif.b     = 32'h0010_0000;
    @(negedge clk);
    dif.start = 1'b0;
    dif.a     = 32'hDEAD_BEEF;
    dif.b     = 32'h0000_0000;
    wait_done(100);
    exp_r = sb.pop_front();
    n_checks++;
    if (obs_to || obs !== exp_r || obs_cyc + 10 != LAT) begin
      n_errors++;
      $display("FAIL ignore_start: out=%h ovf=%b dz=%b lat=%0d, expected out=%h ovf=%b dz=%b lat=%0d",
               obs.out, obs.ovf, obs.dz, obs_cyc + 10, exp_r.out, exp_r.ovf, exp_r.dz, LAT);
    end
    @(negedge clk);
    n_checks++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
      n_errors++;
      $display("FAIL ignore_no_second: busy=%b done=%b, expected busy=0 done=0", dif.busy, dif.done);
    end
  endtask

  task automatic test_back_to_back;
    launch(32'hFF40_0000, 32'h0003_0000, model(32'hFF40_0000, 32'h0003_0000));
    wait_done(100);
    exp_r = sb.pop_front();
    n_checks++;
    if (obs_to || obs !== exp_r) begin
      n_errors++;
      $display("FAIL b2b_first: out=%h ovf=%b dz=%b, expected out=%h ovf=%b dz=%b",
               obs.out, obs.ovf, obs.dz, exp_r.out, exp_r.ovf, exp_r.dz);
    end
    dif.start = 1'b1;
    dif.a     = 32'h0123_4567;
    dif.b     = 32'hFFFE_8000;
    sb.push_back(model(32'h0123_4567, 32'hFFFE_8000));
    @(negedge clk);
    dif.start = 1'b0;
    wait_done(100);
    exp_r = sb.pop_front();
    n_checks++;
    if (obs_to || obs !== exp_r || obs_cyc != LAT) begin
      n_errors++;
      $display("FAIL b2b_second: out=%h ovf=%b dz=%b lat=%0d, expected out=%h ovf=%b dz=%b lat=%0d",
               obs.out, obs.ovf, obs.dz, obs_cyc, exp_r.out, exp_r.ovf, exp_r.dz, LAT);
    end
  endtask

  task automatic test_random;
    logic [N-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom() >> $urandom_range(0, 14);
      if ($urandom_range(0, 1) == 1) a = ~a + 32'd1;
      b = $urandom() >> $urandom_range(4, 28);
      if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
      launch(a, b, model(a, b));
      wait_done(100);
      exp_r = sb.pop_front();
      n_checks++;
      if (obs_to || obs !== exp_r || obs_cyc != ((b == 32'd0) ? 1 : LAT)) begin
        n_errors++;
        $display("FAIL random_%0d a=%h b=%h: out=%h ovf=%b dz=%b lat=%0d, expected out=%h ovf=%b dz=%b",
                 i, a, b, obs.out, obs.ovf, obs.dz, obs_cyc, exp_r.out, exp_r.ovf, exp_r.dz);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    launch(32'h0030_0000, 32'h0020_0000, model(32'h0030_0000, 32'h0020_0000));
    repeat (19) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dif.busy, dif.done, dif.out, dif.ovf, dif.dz} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_async: busy=%b done=%b out=%h ovf=%b dz=%b, expected all zero",
               dif.busy, dif.done, dif.out, dif.ovf, dif.dz);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dif.done === 1'b1 || dif.busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_no_done: activity=%b, expected 0", seen);
    end
    launch(32'h0030_0000, 32'h0020_0000, '{out: 32'h0018_0000, ovf: 1'b0, dz: 1'b0});
    wait_done(100);
    exp_r = sb.pop_front();
    n_checks++;
    if (obs_to || obs !== exp_r || obs_cyc != LAT) begin
      n_errors++;
      $display("FAIL reset_mid_recover: out=%h ovf=%b dz=%b lat=%0d, expected out=%h ovf=%b dz=%b lat=%0d",
               obs.out, obs.ovf, obs.dz, obs_cyc, exp_r.out, exp_r.ovf, exp_r.dz, LAT);
    end
  endtask

  initial begin
    dif.start = 1'b0;
    dif.a     = '0;
    dif.b     = '0;
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
